// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared encodings and FSM state type for the activation scheduler
package act_pkg;

    localparam int FUNC_W = 2;

    localparam logic [FUNC_W-1:0] FUNC_SIGMOID = 2'd0;
    localparam logic [FUNC_W-1:0] FUNC_RELU    = 2'd1;
    localparam logic [FUNC_W-1:0] FUNC_TANH    = 2'd2;
    localparam logic [FUNC_W-1:0] FUNC_PASS    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr_i and wraps
module rr_arbiter
    import act_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] ptr, input int off);
        return IDX_W'((int'(ptr) + off) % NUM_REQ);
    endfunction

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!any_grant_o && req_i[wrap_idx(ptr_i, off)]) begin
                any_grant_o                      = 1'b1;
                grant_idx_o                      = wrap_idx(ptr_i, off);
                grant_o[wrap_idx(ptr_i, off)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/activation_scheduler.sv
// rtl/activation_scheduler.sv - shares one element-serial activation datapath among requesters
module activation_scheduler
    import act_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 8,
    parameter int FUNC_W   = act_pkg::FUNC_W,
    parameter int PIPE_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FUNC_W-1:0] req_func,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        job_done,
    output logic                      busy,
    input  logic                      stall,
    output logic [FUNC_W-1:0]         act_func,
    output logic                      src_rd_en,
    output logic [ADDR_W-1:0]         src_rd_addr,
    output logic                      dst_wr_en,
    output logic [ADDR_W-1:0]         dst_wr_addr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, gidx_q, ptr_nxt;
    logic [FUNC_W-1:0]    func_q;
    logic [ADDR_W-1:0]    base_q;
    logic [LEN_W-1:0]     len_q, idx_q;
    logic [PIPE_LAT-1:0]  dl_v_q;
    logic [ADDR_W-1:0]    dl_a_q [PIPE_LAT];

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    logic                 accept, rd_en, last_issue, pending;
    logic [ADDR_W-1:0]    rd_addr;
    logic [FUNC_W-1:0]    sel_func;
    logic [ADDR_W-1:0]    sel_base;
    logic [LEN_W-1:0]     sel_len;
    logic [PIPE_LAT-1:0]  dl_head;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_grant_o (arb_any)
    );

    assign sel_func   = req_func[arb_idx*FUNC_W +: FUNC_W];
    assign sel_base   = req_base[arb_idx*ADDR_W +: ADDR_W];
    assign sel_len    = req_len[arb_idx*LEN_W +: LEN_W];

    assign accept     = (state_q == ST_IDLE) && arb_any;
    assign rd_en      = (state_q == ST_ISSUE) && !stall;
    assign last_issue = rd_en && (idx_q == len_q - LEN_W'(1));
    assign rd_addr    = base_q + ADDR_W'(idx_q);
    assign ptr_nxt    = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    // The tail entry is being written this cycle, so only earlier stages keep DRAIN alive.
    always_comb begin
        dl_head               = dl_v_q;
        dl_head[PIPE_LAT-1]   = 1'b0;
    end
    assign pending = |dl_head;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_any) state_d = (sel_len == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (!pending) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            func_q  <= '0;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            dl_v_q  <= '0;
            for (int i = 0; i < PIPE_LAT; i++) dl_a_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gidx_q <= arb_idx;
                func_q <= sel_func;
                base_q <= sel_base;
                len_q  <= sel_len;
                idx_q  <= '0;
            end else if (rd_en) begin
                idx_q  <= idx_q + LEN_W'(1);
            end
            if (state_q == ST_DONE) ptr_q <= ptr_nxt;
            dl_v_q[0] <= rd_en;
            dl_a_q[0] <= rd_en ? rd_addr : '0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                dl_a_q[i] <= dl_a_q[i-1];
            end
        end
    end

    assign req_ready   = (state_q == ST_IDLE && !reset) ? arb_grant : '0;
    assign job_done    = (state_q == ST_DONE) ? (NUM_REQ'(1) << gidx_q) : '0;
    assign busy        = (state_q != ST_IDLE);
    assign act_func    = func_q;
    assign src_rd_en   = rd_en;
    assign src_rd_addr = rd_en ? rd_addr : '0;
    assign dst_wr_en   = dl_v_q[PIPE_LAT-1];
    assign dst_wr_addr = dl_a_q[PIPE_LAT-1];

endmodule

// File: tb/tb_activation_scheduler.sv
// tb/tb_activation_scheduler.sv - directed self-checking bench for activation_scheduler
module tb_activation_scheduler;
    import act_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [7:0]  req_func;
    logic [39:0] req_base;
    logic [31:0] req_len;
    logic [3:0]  req_ready, job_done;
    logic        busy, stall;
    logic [1:0]  act_func;
    logic        src_rd_en, dst_wr_en;
    logic [9:0]  src_rd_addr, dst_wr_addr;

    int checks = 0;
    int failures = 0;

    activation_scheduler #(.NUM_REQ(4), .ADDR_W(10), .LEN_W(8), .FUNC_W(2), .PIPE_LAT(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_func(req_func),
        .req_base(req_base), .req_len(req_len), .req_ready(req_ready), .job_done(job_done),
        .busy(busy), .stall(stall), .act_func(act_func), .src_rd_en(src_rd_en),
        .src_rd_addr(src_rd_addr), .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic [1:0] f, input logic [9:0] b, input logic [7:0] l);
        req_func[r*2 +: 2]  = f;
        req_base[r*10 +: 10] = b;
        req_len[r*8 +: 8]   = l;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_func = '0; req_base = '0; req_len = '0; stall = 1'b0;
        next_cycle(); next_cycle(); #1;
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++;
        if (job_done !== 4'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0000", job_done); end
        checks++;
        if ({src_rd_en, dst_wr_en} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {src_rd_en, dst_wr_en}); end
        checks++;
        if ({act_func, src_rd_addr, dst_wr_addr} !== 22'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {act_func, src_rd_addr, dst_wr_addr}); end
        checks++;
        next_cycle(); reset = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0] e_rdy, e_done; logic e_rd, e_wr, e_busy; logic [9:0] e_ra, e_wa;
        for (int k = 0; k <= 8; k++) begin
            next_cycle();
            if (k == 0) begin set_req(2, FUNC_RELU, 10'h010, 8'd3); req_valid = 4'b0100; end
            if (k == 1) req_valid = '0;
            #1;
            e_rdy = (k == 0) ? 4'b0100 : 4'b0000;
            e_done = (k == 6) ? 4'b0100 : 4'b0000;
            e_rd = (k >= 1 && k <= 3); e_ra = 10'(10'h010 + k - 1);
            e_wr = (k >= 3 && k <= 5); e_wa = 10'(10'h010 + k - 3);
            e_busy = (k >= 1 && k <= 6);
            if (req_ready !== e_rdy) begin failures++; $display("FAIL single_ready k=%0d got=%b exp=%b", k, req_ready, e_rdy); end
            checks++;
            if (src_rd_en !== e_rd || (e_rd && src_rd_addr !== e_ra)) begin failures++; $display("FAIL single_rd k=%0d got=%b/%h exp=%b/%h", k, src_rd_en, src_rd_addr, e_rd, e_ra); end
            checks++;
            if (dst_wr_en !== e_wr || (e_wr && dst_wr_addr !== e_wa)) begin failures++; $display("FAIL single_wr k=%0d got=%b/%h exp=%b/%h", k, dst_wr_en, dst_wr_addr, e_wr, e_wa); end
            checks++;
            if (job_done !== e_done) begin failures++; $display("FAIL single_done k=%0d got=%b exp=%b", k, job_done, e_done); end
            checks++;
            if (busy !== e_busy) begin failures++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, e_busy); end
            checks++;
            if (e_busy && act_func !== FUNC_RELU) begin failures++; $display("FAIL single_func k=%0d got=%0d exp=%0d", k, act_func, FUNC_RELU); end
            checks++;
        end
    endtask

    task automatic test_round_robin();
        int g, p; logic [3:0] e_rdy, e_done; logic e_rd;
        next_cycle();
        reset = 1'b1;
        for (int r = 0; r < 4; r++) set_req(r, 2'(r), 10'(10'h040 * r), 8'd1);
        req_valid = 4'hF;
        next_cycle();
        for (int k = 0; k <= 24; k++) begin
            next_cycle();
            if (k == 0) reset = 1'b0;
            if (k == 21) req_valid = '0;
            #1;
            g = (k / 5) % 4; p = k % 5;
            e_rdy = (p == 0) ? (4'b0001 << g) : 4'b0000;
            e_done = (p == 4) ? (4'b0001 << g) : 4'b0000;
            e_rd = (p == 1);
            if (req_ready !== e_rdy) begin failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, e_rdy); end
            checks++;
            if (job_done !== e_done) begin failures++; $display("FAIL rr_done k=%0d got=%b exp=%b", k, job_done, e_done); end
            checks++;
            if (src_rd_en !== e_rd || (e_rd && src_rd_addr !== 10'(10'h040 * g))) begin failures++; $display("FAIL rr_rd k=%0d got=%b/%h", k, src_rd_en, src_rd_addr); end
            checks++;
            if (p != 0 && act_func !== 2'(g)) begin failures++; $display("FAIL rr_func k=%0d got=%0d exp=%0d", k, act_func, g); end
            checks++;
        end
    endtask

    task automatic test_stall();
        logic [3:0] e_rdy, e_done; logic e_rd, e_wr; logic [9:0] e_ra, e_wa;
        for (int k = 0; k <= 10; k++) begin
            next_cycle();
            if (k == 0) begin set_req(0, FUNC_PASS, 10'h100, 8'd4); req_valid = 4'b0001; end
            if (k == 1) begin req_valid = '0; set_req(0, FUNC_SIGMOID, 10'h2AA, 8'd9); end
            stall = (k == 2 || k == 3 || k == 7 || k == 8);
            #1;
            e_rdy = (k == 0) ? 4'b0001 : 4'b0000;
            e_done = (k == 9) ? 4'b0001 : 4'b0000;
            e_rd = (k == 1 || (k >= 4 && k <= 6)); e_ra = 10'(10'h100 + ((k == 1) ? 0 : k - 3));
            e_wr = (k == 3 || (k >= 6 && k <= 8)); e_wa = 10'(10'h100 + ((k == 3) ? 0 : k - 5));
            if (req_ready !== e_rdy) begin failures++; $display("FAIL stall_ready k=%0d got=%b exp=%b", k, req_ready, e_rdy); end
            checks++;
            if (src_rd_en !== e_rd || (e_rd && src_rd_addr !== e_ra)) begin failures++; $display("FAIL stall_rd k=%0d got=%b/%h exp=%b/%h", k, src_rd_en, src_rd_addr, e_rd, e_ra); end
            checks++;
            if (dst_wr_en !== e_wr || (e_wr && dst_wr_addr !== e_wa)) begin failures++; $display("FAIL stall_wr k=%0d got=%b/%h exp=%b/%h", k, dst_wr_en, dst_wr_addr, e_wr, e_wa); end
            checks++;
            if (job_done !== e_done) begin failures++; $display("FAIL stall_done k=%0d got=%b exp=%b", k, job_done, e_done); end
            checks++;
            if (k >= 1 && k <= 9 && act_func !== FUNC_PASS) begin failures++; $display("FAIL stall_func k=%0d got=%0d exp=%0d", k, act_func, FUNC_PASS); end
            checks++;
        end
        stall = 1'b0;
    endtask

    task automatic test_addr_wrap();
        logic [3:0] e_done; logic e_rd, e_wr; logic [9:0] e_ra, e_wa;
        for (int k = 0; k <= 8; k++) begin
            next_cycle();
            if (k == 0) begin set_req(3, FUNC_TANH, 10'h3FE, 8'd4); req_valid = 4'b1000; end
            if (k == 1) req_valid = '0;
            #1;
            e_done = (k == 7) ? 4'b1000 : 4'b0000;
            e_rd = (k >= 1 && k <= 4); e_ra = 10'(10'h3FE + k - 1);
            e_wr = (k >= 3 && k <= 6); e_wa = 10'(10'h3FE + k - 3);
            if (k == 0 && req_ready !== 4'b1000) begin failures++; $display("FAIL wrap_ready got=%b exp=1000", req_ready); end
            checks++;
            if (src_rd_en !== e_rd || (e_rd && src_rd_addr !== e_ra)) begin failures++; $display("FAIL wrap_rd k=%0d got=%b/%h exp=%b/%h", k, src_rd_en, src_rd_addr, e_rd, e_ra); end
            checks++;
            if (dst_wr_en !== e_wr || (e_wr && dst_wr_addr !== e_wa)) begin failures++; $display("FAIL wrap_wr k=%0d got=%b/%h exp=%b/%h", k, dst_wr_en, dst_wr_addr, e_wr, e_wa); end
            checks++;
            if (job_done !== e_done) begin failures++; $display("FAIL wrap_done k=%0d got=%b exp=%b", k, job_done, e_done); end
            checks++;
        end
    endtask

    task automatic test_len_zero();
        logic [3:0] e_rdy, e_done; logic e_rd, e_wr;
        for (int k = 0; k <= 7; k++) begin
            next_cycle();
            if (k == 0) begin set_req(1, FUNC_SIGMOID, 10'h155, 8'd0); req_valid = 4'b0010; end
            if (k == 1) req_valid = '0;
            if (k == 2) begin
                for (int r = 0; r < 4; r++) set_req(r, FUNC_RELU, 10'(10'h020 + r), 8'd1);
                req_valid = 4'hF;
            end
            if (k == 3) req_valid = '0;
            #1;
            e_rdy = (k == 0) ? 4'b0010 : (k == 2) ? 4'b0100 : 4'b0000;
            e_done = (k == 1) ? 4'b0010 : (k == 6) ? 4'b0100 : 4'b0000;
            e_rd = (k == 3); e_wr = (k == 5);
            if (req_ready !== e_rdy) begin failures++; $display("FAIL len0_ready k=%0d got=%b exp=%b", k, req_ready, e_rdy); end
            checks++;
            if (job_done !== e_done) begin failures++; $display("FAIL len0_done k=%0d got=%b exp=%b", k, job_done, e_done); end
            checks++;
            if (src_rd_en !== e_rd || (e_rd && src_rd_addr !== 10'h022)) begin failures++; $display("FAIL len0_rd k=%0d got=%b/%h exp=%b", k, src_rd_en, src_rd_addr, e_rd); end
            checks++;
            if (dst_wr_en !== e_wr) begin failures++; $display("FAIL len0_wr k=%0d got=%b exp=%b", k, dst_wr_en, e_wr); end
            checks++;
            if (k <= 2 && busy !== (k == 1)) begin failures++; $display("FAIL len0_busy k=%0d got=%b", k, busy); end
            checks++;
        end
    endtask

    task automatic test_reset_mid_job();
        logic [3:0] e_rdy, e_done; logic e_rd, e_wr, e_busy; logic [9:0] e_ra;
        for (int k = 0; k <= 16; k++) begin
            next_cycle();
            if (k == 0) begin set_req(2, FUNC_TANH, 10'h080, 8'd5); req_valid = 4'b0100; end
            if (k == 1) req_valid = '0;
            if (k == 2) reset = 1'b1;
            if (k == 4) reset = 1'b0;
            if (k == 10) begin
                for (int r = 0; r < 4; r++) set_req(r, FUNC_RELU, 10'(10'h200 + 10'h010 * r), 8'd2);
                req_valid = 4'hF;
            end
            if (k == 11) req_valid = '0;
            #1;
            e_rdy = (k == 0) ? 4'b0100 : (k == 10) ? 4'b0001 : 4'b0000;
            e_done = (k == 15) ? 4'b0001 : 4'b0000;
            e_rd = (k == 1 || k == 11 || k == 12); e_ra = (k == 1) ? 10'h080 : 10'(10'h200 + k - 11);
            e_wr = (k == 13 || k == 14);
            e_busy = (k >= 1 && k <= 2) || (k >= 11 && k <= 15);
            if (req_ready !== e_rdy) begin failures++; $display("FAIL rst_ready k=%0d got=%b exp=%b", k, req_ready, e_rdy); end
            checks++;
            if (job_done !== e_done) begin failures++; $display("FAIL rst_done k=%0d got=%b exp=%b", k, job_done, e_done); end
            checks++;
            if (dst_wr_en !== e_wr) begin failures++; $display("FAIL rst_wr k=%0d got=%b exp=%b", k, dst_wr_en, e_wr); end
            checks++;
            if (k != 2 && (src_rd_en !== e_rd || (e_rd && src_rd_addr !== e_ra))) begin failures++; $display("FAIL rst_rd k=%0d got=%b/%h exp=%b/%h", k, src_rd_en, src_rd_addr, e_rd, e_ra); end
            checks++;
            if (k != 2 && busy !== e_busy) begin failures++; $display("FAIL rst_busy k=%0d got=%b exp=%b", k, busy, e_busy); end
            checks++;
            if (k >= 3 && k <= 10 && act_func !== 2'd0) begin failures++; $display("FAIL rst_func k=%0d got=%0d exp=0", k, act_func); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_addr_wrap();
        test_len_zero();
        test_reset_mid_job();
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
